// File: rtl/deferred_step_batcher.sv
// Multi-channel step batcher: accumulates per-channel step counts, emits (channel, count)
// records by round-robin, and drains everything once the sticky deferred result is raised.
module deferred_step_batcher #(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned STEP_W       = 8,
    parameter int unsigned ACC_W        = 16,
    parameter int unsigned BATCH_THRESH = 64,
    parameter int unsigned TIMEOUT      = 255,
    localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_CH*STEP_W-1:0] step,
    input  logic                     result_set,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH_W-1:0]          out_ch,
    output logic [ACC_W-1:0]         out_step,
    output logic                     simv_result,
    output logic                     drained,
    output logic [NUM_CH-1:0]        overflow
);

    localparam int unsigned AGE_W = $clog2(TIMEOUT + 1);

    logic [ACC_W-1:0]  acc_q [NUM_CH];
    logic [ACC_W-1:0]  acc_d [NUM_CH];
    logic [AGE_W-1:0]  age_q [NUM_CH];
    logic [AGE_W-1:0]  age_d [NUM_CH];
    logic [NUM_CH-1:0] pending_c;
    logic [NUM_CH-1:0] ovf_d;
    logic [CH_W-1:0]   ptr_q;
    logic [CH_W-1:0]   grant_c;
    logic              found_c;
    logic              load_c;
    logic              valid_d;
    logic              simv_d;
    logic              drained_d;
    logic              all_zero_c;
    logic [STEP_W-1:0] step_eff;
    logic [ACC_W:0]    sum_c;
    int unsigned       rr_idx;

    // A nonzero channel is pending on threshold, age timeout, or while draining.
    always_comb begin
        pending_c = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            pending_c[i] = (acc_q[i] != '0) &&
                           ((acc_q[i] >= ACC_W'(BATCH_THRESH)) ||
                            (age_q[i] >= AGE_W'(TIMEOUT)) || simv_result);
        end
    end

    // Round-robin grant starting one past the last granted channel.
    always_comb begin
        found_c = 1'b0;
        grant_c = '0;
        rr_idx  = 0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            rr_idx = (32'(ptr_q) + k) % NUM_CH;
            if (!found_c && pending_c[CH_W'(rr_idx)]) begin
                found_c = 1'b1;
                grant_c = CH_W'(rr_idx);
            end
        end
        load_c = found_c && (!out_valid || out_ready);
    end

    // Per-channel accumulate/saturate/age; a loaded channel restarts from its same-cycle step.
    always_comb begin
        all_zero_c = 1'b1;
        step_eff   = '0;
        sum_c      = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            step_eff = simv_result ? '0 : step[i*STEP_W +: STEP_W];
            sum_c    = {1'b0, acc_q[i]} + (ACC_W+1)'(step_eff);
            ovf_d[i] = overflow[i];
            if (load_c && (grant_c == CH_W'(i))) begin
                acc_d[i] = ACC_W'(step_eff);
            end else if (sum_c[ACC_W]) begin
                acc_d[i] = '1;
                ovf_d[i] = 1'b1;
            end else begin
                acc_d[i] = sum_c[ACC_W-1:0];
            end
            if ((load_c && (grant_c == CH_W'(i))) || (acc_q[i] == '0)) begin
                age_d[i] = '0;
            end else if (age_q[i] != AGE_W'(TIMEOUT)) begin
                age_d[i] = age_q[i] + AGE_W'(1);
            end else begin
                age_d[i] = age_q[i];
            end
            if (acc_d[i] != '0) begin
                all_zero_c = 1'b0;
            end
        end
        valid_d   = load_c ? 1'b1 : (out_ready ? 1'b0 : out_valid);
        simv_d    = simv_result | result_set;
        drained_d = simv_d && all_zero_c && !valid_d;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                acc_q[i] <= '0;
                age_q[i] <= '0;
            end
            ptr_q       <= CH_W'(NUM_CH - 1);
            out_valid   <= 1'b0;
            out_ch      <= '0;
            out_step    <= '0;
            simv_result <= 1'b0;
            drained     <= 1'b0;
            overflow    <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                acc_q[i] <= acc_d[i];
                age_q[i] <= age_d[i];
            end
            if (load_c) begin
                ptr_q    <= grant_c;
                out_ch   <= grant_c;
                out_step <= acc_q[grant_c];
            end
            out_valid   <= valid_d;
            simv_result <= simv_d;
            drained     <= drained_d;
            overflow    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_deferred_step_batcher.sv
// Scoreboard bench for deferred_step_batcher: directed phases push hand-computed records,
// a negedge monitor pops and compares every accepted record.
module tb_deferred_step_batcher;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned STEP_W = 8;
    localparam int unsigned ACC_W  = 16;
    localparam int unsigned CH_W   = 1;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [ACC_W-1:0] cnt;
    } rec_t;

    logic                     clock;
    logic                     reset;
    logic [NUM_CH*STEP_W-1:0] step;
    logic                     result_set;
    logic                     out_valid;
    logic                     out_ready;
    logic [CH_W-1:0]          out_ch;
    logic [ACC_W-1:0]         out_step;
    logic                     simv_result;
    logic                     drained;
    logic [NUM_CH-1:0]        overflow;

    rec_t sb[$];
    int   n_cmp;
    int   n_bad;

    deferred_step_batcher #(
        .NUM_CH(NUM_CH), .STEP_W(STEP_W), .ACC_W(ACC_W),
        .BATCH_THRESH(64), .TIMEOUT(8)
    ) dut (
        .clock(clock), .reset(reset), .step(step), .result_set(result_set),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .out_step(out_step), .simv_result(simv_result), .drained(drained),
        .overflow(overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push(input int ch, input int cnt);
        rec_t r;
        r.ch  = CH_W'(ch);
        r.cnt = ACC_W'(cnt);
        sb.push_back(r);
    endtask

    // Monitor: every accepted record must match the oldest expected one.
    always @(negedge clock) begin
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_record: got ch %0d cnt %0d expected none", out_ch, out_step);
            end else begin
                rec_t e;
                e = sb.pop_front();
                chk("rec_ch", 32'(out_ch), 32'(e.ch));
                chk("rec_cnt", 32'(out_step), 32'(e.cnt));
            end
        end
    end

    initial begin
        int n;
        n_cmp      = 0;
        n_bad      = 0;
        reset      = 1'b0;
        step       = {8'h10, 8'h10};
        result_set = 1'b0;
        out_ready  = 1'b0;

        // Reset held with nonzero steps
        cyc(3);
        @(negedge clock);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_simv", 32'(simv_result), 0);
        chk("rst_drained", 32'(drained), 0);
        chk("rst_overflow", 32'(overflow), 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        step  = '0;
        repeat (4) begin
            @(negedge clock);
            chk("idle_valid", 32'(out_valid), 0);
        end

        // Threshold: ch0 16/cycle for 20 cycles -> five records of 64
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        repeat (5) push(0, 64);
        step = {8'd0, 8'd16};
        cyc(20);
        step = '0;
        cyc(10);
        chk("thresh_sb_empty", 32'(sb.size()), 0);

        // Backpressure + round robin: grant ch1 first (ptr=0), hold, then 0 and 1
        out_ready = 1'b0;
        push(1, 64);
        push(0, 128);
        push(1, 64);
        step = {8'd32, 8'd32};
        cyc(4);
        step = '0;
        repeat (18) begin
            @(negedge clock);
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_ch", 32'(out_ch), 1);
            chk("bp_cnt", 32'(out_step), 64);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        cyc(6);
        chk("bp_sb_empty", 32'(sb.size()), 0);

        // Timeout: a single step of 1 on ch1 is flushed after the age limit
        push(1, 1);
        step = {8'd1, 8'd0};
        @(posedge clock);
        #1;
        step = '0;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (out_valid) begin
                n = k;
                break;
            end
        end
        chk("timeout_latency_ok", 32'((n >= 9) && (n <= 10)), 1);
        cyc(3);
        chk("timeout_sb_empty", 32'(sb.size()), 0);

        // Saturation under backpressure with a held record
        out_ready = 1'b0;
        step = {8'd64, 8'd0};
        cyc(1);
        step = '0;
        cyc(2);
        step = {8'd0, 8'd255};
        cyc(257);
        @(negedge clock);
        chk("sat_edge_no_ovf", 32'(overflow), 0);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("sat_ovf", 32'(overflow), 1);
        chk("sat_hold_valid", 32'(out_valid), 1);
        chk("sat_hold_ch", 32'(out_ch), 1);
        chk("sat_hold_cnt", 32'(out_step), 64);
        @(posedge clock);
        #1;
        step = '0;
        push(1, 64);
        push(0, 65535);
        out_ready = 1'b1;
        cyc(5);
        chk("sat_sb_empty", 32'(sb.size()), 0);
        chk("sat_ovf_sticky", 32'(overflow), 1);

        // Drain: same-cycle step counts, later steps ignored; ptr=0 so ch1 goes first
        push(1, 8);
        push(0, 10);
        step = {8'd5, 8'd10};
        cyc(1);
        @(negedge clock);
        chk("drain_simv_low", 32'(simv_result), 0);
        step       = {8'd3, 8'd0};
        result_set = 1'b1;
        cyc(1);
        result_set = 1'b0;
        step       = {8'd7, 8'd7};
        @(negedge clock);
        chk("drain_simv_high", 32'(simv_result), 1);
        chk("drain_not_yet", 32'(drained), 0);
        cyc(2);
        @(negedge clock);
        chk("drain_last_valid", 32'(drained), 0);
        cyc(1);
        @(negedge clock);
        chk("drained_rise", 32'(drained), 1);
        repeat (5) begin
            @(posedge clock);
            #1;
            @(negedge clock);
            chk("drained_stay", 32'(drained), 1);
            chk("drain_idle_valid", 32'(out_valid), 0);
        end
        chk("drain_sb_empty", 32'(sb.size()), 0);
        chk("drain_ovf_sticky", 32'(overflow), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
